snake_frame_scheduler: RTL and testbench
========================================

# snake_frame_scheduler

Per-frame scheduler that walks the snake segment arrays once per video frame and builds a tile-occupancy map for the VGA pixel path. The map is double-buffered, so the renderer never sees a partially built frame. The block sits between the game logic (flat 32-bit x/y segment buses) and the pixel-colour mux. It is triggered by the timing generator's `screenEnd` pulse, runs during blanking, and also reports head-on-body collision and head out-of-bounds.

## Interface
- `GRID_W`, 10: board width in tiles (40 px tiles from x=48).
- `GRID_H`, 10: board height in tiles (40 px tiles from y=48).
- `MAX_SEG`, 100: segment slots in the flat buses.
- `COORD_W`, 32: bits per coordinate slot.
- `clk`  in  1  system clock, single domain.
- `reset`  in  1  synchronous, active-low reset.
- `frame_start`  in  1  one-cycle pulse (`screenEnd`) requesting a map rebuild.
- `game_done`  in  1  when high, `frame_start` is ignored and the displayed map freezes.
- `snake_len`  in  7  live segment count; 0 is treated as 1, values above `MAX_SEG` are clamped to `MAX_SEG`.
- `x_values`  in  MAX_SEG*COORD_W  tile x of segment i at bits [32i+31:32i]; segment 0 is the head.
- `y_values`  in  MAX_SEG*COORD_W  tile y, same packing as `x_values`.
- `rd_tx`  in  4  pixel-side read: tile column.
- `rd_ty`  in  4  pixel-side read: tile row.
- `rd_occ`  out  1  registered: tile (`rd_tx`, `rd_ty`) is occupied in the displayed map.
- `rd_is_head`  out  1  registered: tile is the displayed head tile.
- `busy`  out  1  high from the cycle after an accepted `frame_start` through COMMIT.
- `frame_done`  out  1  one-cycle pulse in the cycle after COMMIT.
- `collision`  out  1  sticky per frame: head tile equals some body tile.
- `out_of_bounds`  out  1  per frame: head x ≥ `GRID_W` or head y ≥ `GRID_H`.

## Operation
- FSM states are IDLE, CLEAR, SCAN, COMMIT.
- IDLE: `frame_start`=1 and `game_done`=0 → latch the clamped length as `len_q` and go to CLEAR. Otherwise stay in IDLE.
- CLEAR: zero the shadow map and the shadow flags, set index i=0, go to SCAN.
- SCAN, one segment per cycle:
  - Read slot i of `x_values`/`y_values`. Comparisons are unsigned over the full `COORD_W` bits.
  - Segment is in range if x<`GRID_W` and y<`GRID_H`. In range → set shadow bit y*`GRID_W`+x.
  - i=0: record the head tile and its range status. Out of range → set shadow OOB and do not set a bit.
  - i≥1, in range, tile equals the in-range head tile → set shadow collision.
  - Out-of-range body segments are skipped silently.
  - When i=`len_q`-1, go to COMMIT. Otherwise increment i.
- COMMIT: copy the shadow map, head tile, head-valid, collision and OOB into the display registers, then go to IDLE.
- `frame_start` while `busy` is ignored; it is neither queued nor does it restart the scan.
- `x_values`/`y_values` are sampled live. The game logic holds them stable for the `len_q`+2 cycles after `frame_start`.
- Reads always come from the display map only. `rd_tx`≥`GRID_W` or `rd_ty`≥`GRID_H` → `rd_occ`=`rd_is_head`=0.
- `rd_is_head`=0 when the displayed head was out of bounds.

## Timing
- Reset (`reset`=0 at a clock edge) → state IDLE, i=0, both maps cleared, head-valid=0.
- Every output reads 0 out of reset: `rd_occ`, `rd_is_head`, `busy`, `frame_done`, `collision`, `out_of_bounds`.
- Reset asserted mid-SCAN aborts the scan. The display map is also cleared.
- `frame_start` accepted at edge t:
  - CLEAR at t+1.
  - SCAN at t+2 .. t+1+`len_q`.
  - COMMIT at t+2+`len_q`.
  - New display map, flags and a `frame_done` pulse at t+3+`len_q`.
- Worst case (`len_q`=100): 103 cycles, well inside vertical blanking.
- Read port latency is 1 cycle: the address at edge t yields the result after edge t+1.
- A read during COMMIT returns the old map. The new map is visible to addresses sampled from t+3+`len_q` onward.
- `collision` and `out_of_bounds` hold their values until the next COMMIT.

## Structure
- Shared package `snake_pkg`:
  - constants `GRID_W`, `GRID_H`, `MAX_SEG`, `COORD_W`, `TILE_PX`=40, `BOARD_X0`=48, `BOARD_Y0`=48;
  - the FSM state encoding.
- One sub-module, `snake_occ_map`:
  - `GRID_W`*`GRID_H`-bit shadow and display registers;
  - ports for clear, set-bit, commit, and the registered read.
- Top level: the FSM, segment index, slot mux and compare logic.

## Test plan
- Reset check: drive `reset`=0 for 2 cycles → all outputs 0, `busy`=0, a read of tile (0,0) returns 0.
- Basic scan: len=3, segments (2,2),(1,2),(0,2), pulse `frame_start` → `frame_done` 6 cycles later; tiles (2,2),(1,2),(0,2) read occupied, (2,2) reads as head, (3,2) reads 0, `collision`=0.
- Collision: len=5, head (4,4), segment 3 at (4,4) → `collision`=1 after `frame_done`; a following clean frame clears it to 0.
- Bounds: head x=10, len=2, segment 1 at (0,0) → `out_of_bounds`=1, `rd_is_head` never 1, tile (0,0) occupied; len=0 is scanned as 1 segment; len=127 is scanned as 100 segments (103-cycle latency).
- Busy and freeze:
  - A second `frame_start` mid-SCAN → ignored; exactly one `frame_done`.
  - `game_done`=1 plus `frame_start` → no `busy`, display map unchanged.
  - `reset` mid-SCAN → IDLE with an empty map.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared constants, FSM encoding and length clamp for the snake frame scheduler.
package snake_pkg;

    localparam int GRID_W   = 10;
    localparam int GRID_H   = 10;
    localparam int MAX_SEG  = 100;
    localparam int COORD_W  = 32;
    localparam int TILE_PX  = 40;
    localparam int BOARD_X0 = 48;
    localparam int BOARD_Y0 = 48;
    localparam int MAP_BITS = GRID_W * GRID_H;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SCAN,
        ST_COMMIT
    } sched_state_t;

    // An empty snake still has a head slot to scan; the buses only hold MAX_SEG slots.
    function automatic logic [6:0] clamp_len(input logic [6:0] len);
        if (len == 7'd0)
            return 7'd1;
        if (len > 7'(MAX_SEG))
            return 7'(MAX_SEG);
        return len;
    endfunction

endpackage

// File: rtl/snake_occ_map.sv
// Double-buffered tile occupancy map: shadow is built during a scan, display feeds the pixel path.
module snake_occ_map
    import snake_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       set_en,
    input  logic [6:0] set_idx,
    input  logic       commit,
    input  logic [3:0] rd_tx,
    input  logic [3:0] rd_ty,
    output logic       rd_occ
);

    logic [MAP_BITS-1:0] shadow_map;
    logic [MAP_BITS-1:0] display_map;
    logic                rd_in_range;
    logic [6:0]          rd_idx;

    assign rd_in_range = (rd_tx < 4'(GRID_W)) && (rd_ty < 4'(GRID_H));
    assign rd_idx      = 7'(rd_ty) * 7'(GRID_W) + 7'(rd_tx);

    // Reads see the display copy only, so a read during COMMIT still returns the old frame.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shadow_map  <= '0;
            display_map <= '0;
            rd_occ      <= 1'b0;
        end else begin
            if (clear)
                shadow_map <= '0;
            else if (set_en)
                shadow_map[set_idx] <= 1'b1;
            if (commit)
                display_map <= shadow_map;
            rd_occ <= rd_in_range && display_map[rd_idx];
        end
    end

endmodule

// File: rtl/snake_frame_scheduler.sv
// Per-frame scan of the snake segment buses into a tile map, with head collision and bounds flags.
module snake_frame_scheduler
    import snake_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       frame_start,
    input  logic                       game_done,
    input  logic [6:0]                 snake_len,
    input  logic [MAX_SEG*COORD_W-1:0] x_values,
    input  logic [MAX_SEG*COORD_W-1:0] y_values,
    input  logic [3:0]                 rd_tx,
    input  logic [3:0]                 rd_ty,
    output logic                       rd_occ,
    output logic                       rd_is_head,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       collision,
    output logic                       out_of_bounds
);

    sched_state_t state;
    logic [6:0]   idx_q;
    logic [6:0]   len_q;

    logic [COORD_W-1:0] seg_x;
    logic [COORD_W-1:0] seg_y;
    logic               seg_in_range;
    logic [6:0]         seg_tile;
    logic               seg_hits_head;

    logic [3:0] head_x_s, head_y_s, head_x_d, head_y_d;
    logic       head_valid_s, head_valid_d;
    logic       coll_s, oob_s;

    assign seg_x = x_values[int'(idx_q) * COORD_W +: COORD_W];
    assign seg_y = y_values[int'(idx_q) * COORD_W +: COORD_W];

    // Full-width unsigned compare so huge coordinates never alias onto the board.
    assign seg_in_range  = (seg_x < COORD_W'(GRID_W)) && (seg_y < COORD_W'(GRID_H));
    assign seg_tile      = 7'(seg_y[3:0]) * 7'(GRID_W) + 7'(seg_x[3:0]);
    assign seg_hits_head = head_valid_s && (seg_x[3:0] == head_x_s) && (seg_y[3:0] == head_y_s);

    snake_occ_map u_map (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == ST_CLEAR),
        .set_en  ((state == ST_SCAN) && seg_in_range),
        .set_idx (seg_tile),
        .commit  (state == ST_COMMIT),
        .rd_tx   (rd_tx),
        .rd_ty   (rd_ty),
        .rd_occ  (rd_occ)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ST_IDLE;
            idx_q         <= '0;
            len_q         <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            head_x_s      <= '0;
            head_y_s      <= '0;
            head_valid_s  <= 1'b0;
            coll_s        <= 1'b0;
            oob_s         <= 1'b0;
            head_x_d      <= '0;
            head_y_d      <= '0;
            head_valid_d  <= 1'b0;
            collision     <= 1'b0;
            out_of_bounds <= 1'b0;
            rd_is_head    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            rd_is_head <= head_valid_d && (rd_tx == head_x_d) && (rd_ty == head_y_d);
            case (state)
                ST_IDLE: begin
                    if (frame_start && !game_done) begin
                        len_q <= clamp_len(snake_len);
                        busy  <= 1'b1;
                        state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    head_x_s     <= '0;
                    head_y_s     <= '0;
                    head_valid_s <= 1'b0;
                    coll_s       <= 1'b0;
                    oob_s        <= 1'b0;
                    idx_q        <= '0;
                    state        <= ST_SCAN;
                end
                ST_SCAN: begin
                    // Slot 0 is the head; only body slots can collide with it.
                    if (idx_q == 7'd0) begin
                        head_x_s     <= seg_x[3:0];
                        head_y_s     <= seg_y[3:0];
                        head_valid_s <= seg_in_range;
                        oob_s        <= !seg_in_range;
                    end else if (seg_in_range && seg_hits_head) begin
                        coll_s <= 1'b1;
                    end
                    if (idx_q == len_q - 7'd1)
                        state <= ST_COMMIT;
                    else
                        idx_q <= idx_q + 7'd1;
                end
                ST_COMMIT: begin
                    head_x_d      <= head_x_s;
                    head_y_d      <= head_y_s;
                    head_valid_d  <= head_valid_s;
                    collision     <= coll_s;
                    out_of_bounds <= oob_s;
                    frame_done    <= 1'b1;
                    busy          <= 1'b0;
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_frame_scheduler.sv
// Randomized self-checking bench for snake_frame_scheduler against a set-based frame model.
module tb_snake_frame_scheduler;
    import snake_pkg::*;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       frame_start;
    logic                       game_done;
    logic [6:0]                 snake_len;
    logic [MAX_SEG*COORD_W-1:0] x_values;
    logic [MAX_SEG*COORD_W-1:0] y_values;
    logic [3:0]                 rd_tx;
    logic [3:0]                 rd_ty;
    logic                       rd_occ;
    logic                       rd_is_head;
    logic                       busy;
    logic                       frame_done;
    logic                       collision;
    logic                       out_of_bounds;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] seg_x [MAX_SEG];
    logic [31:0] seg_y [MAX_SEG];

    bit          exp_map [MAP_BITS];
    bit          exp_hv;
    int unsigned exp_hx, exp_hy;
    bit          exp_coll;
    bit          exp_oob;

    always #5 clk = ~clk;

    snake_frame_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .frame_start   (frame_start),
        .game_done     (game_done),
        .snake_len     (snake_len),
        .x_values      (x_values),
        .y_values      (y_values),
        .rd_tx         (rd_tx),
        .rd_ty         (rd_ty),
        .rd_occ        (rd_occ),
        .rd_is_head    (rd_is_head),
        .busy          (busy),
        .frame_done    (frame_done),
        .collision     (collision),
        .out_of_bounds (out_of_bounds)
    );

    // Expected displayed state after a committed frame, straight from the tile rules.
    task automatic model_frame(input int len);
        int n;
        n = (len == 0) ? 1 : ((len > MAX_SEG) ? MAX_SEG : len);
        for (int t = 0; t < MAP_BITS; t++) exp_map[t] = 1'b0;
        exp_hv   = (seg_x[0] < GRID_W) && (seg_y[0] < GRID_H);
        exp_hx   = seg_x[0];
        exp_hy   = seg_y[0];
        exp_oob  = !exp_hv;
        exp_coll = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (seg_x[i] < GRID_W && seg_y[i] < GRID_H) begin
                exp_map[seg_y[i] * GRID_W + seg_x[i]] = 1'b1;
                if (i > 0 && exp_hv && seg_x[i] == seg_x[0] && seg_y[i] == seg_y[0])
                    exp_coll = 1'b1;
            end
        end
    endtask

    task automatic model_empty();
        for (int t = 0; t < MAP_BITS; t++) exp_map[t] = 1'b0;
        exp_hv = 1'b0; exp_hx = 0; exp_hy = 0; exp_coll = 1'b0; exp_oob = 1'b0;
    endtask

    function automatic bit exp_occ(input int tx, input int ty);
        if (tx >= GRID_W || ty >= GRID_H) return 1'b0;
        return exp_map[ty * GRID_W + tx];
    endfunction

    function automatic bit exp_head(input int tx, input int ty);
        return exp_hv && (tx == int'(exp_hx)) && (ty == int'(exp_hy));
    endfunction

    task automatic load_segments();
        for (int i = 0; i < MAX_SEG; i++) begin
            x_values[i*COORD_W +: COORD_W] = seg_x[i];
            y_values[i*COORD_W +: COORD_W] = seg_y[i];
        end
    endtask

    task automatic clear_segments();
        for (int i = 0; i < MAX_SEG; i++) begin
            seg_x[i] = 32'd0;
            seg_y[i] = 32'd0;
        end
    endtask

    // Called at a negedge; returns the clock edge (counted from acceptance) at which frame_done is sampled high, or -1.
    task automatic run_frame(input int len, output int latency, output bit busy_after, output bit coll_held);
        int k;
        snake_len = 7'(len);
        load_segments();
        frame_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        frame_start = 1'b0;
        busy_after = busy;
        coll_held  = collision;
        k = 0;
        while (!frame_done && k < 200) begin
            @(negedge clk);
            k++;
        end
        latency = frame_done ? k + 1 : -1;
    endtask

    task automatic read_tile(input int tx, input int ty, output bit occ, output bit head);
        rd_tx = 4'(tx);
        rd_ty = 4'(ty);
        @(negedge clk);
        occ  = rd_occ;
        head = rd_is_head;
    endtask

    task automatic test_reset();
        bit occ, head;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({rd_occ, rd_is_head, busy, frame_done, collision, out_of_bounds} !== 6'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %b expected 000000",
                     {rd_occ, rd_is_head, busy, frame_done, collision, out_of_bounds});
        end
        reset = 1'b1;
        read_tile(0, 0, occ, head);
        vectors++;
        if ({occ, head} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL reset_read00: got occ=%0d head=%0d expected 0 0", occ, head);
        end
        model_empty();
    endtask

    task automatic test_basic();
        int lat;
        bit b, c, occ, head;
        int tx [4] = '{2, 1, 0, 3};
        bit eo [4] = '{1, 1, 1, 0};
        bit eh [4] = '{1, 0, 0, 0};
        clear_segments();
        seg_x[0] = 2; seg_y[0] = 2;
        seg_x[1] = 1; seg_y[1] = 2;
        seg_x[2] = 0; seg_y[2] = 2;
        run_frame(3, lat, b, c);
        vectors++;
        if (lat !== 6) begin
            miscompares++;
            $display("[TB] FAIL basic_latency: got %0d expected 6", lat);
        end
        vectors++;
        if (b !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL basic_busy: got %0d expected 1", b);
        end
        @(negedge clk);
        vectors++;
        if ({frame_done, busy, collision, out_of_bounds} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL basic_after: got done/busy/coll/oob=%b expected 0000",
                     {frame_done, busy, collision, out_of_bounds});
        end
        for (int i = 0; i < 4; i++) begin
            read_tile(tx[i], 2, occ, head);
            vectors++;
            if (occ !== eo[i] || head !== eh[i]) begin
                miscompares++;
                $display("[TB] FAIL basic_read(%0d,2): got occ=%0d head=%0d expected %0d %0d",
                         tx[i], occ, head, eo[i], eh[i]);
            end
        end
        model_frame(3);
    endtask

    task automatic test_collision();
        int lat;
        bit b, c;
        clear_segments();
        seg_x[0] = 4; seg_y[0] = 4;
        seg_x[1] = 5; seg_y[1] = 4;
        seg_x[2] = 5; seg_y[2] = 5;
        seg_x[3] = 4; seg_y[3] = 4;
        seg_x[4] = 3; seg_y[4] = 4;
        run_frame(5, lat, b, c);
        vectors++;
        if (collision !== 1'b1 || lat !== 8) begin
            miscompares++;
            $display("[TB] FAIL collision_set: got coll=%0d lat=%0d expected 1 8", collision, lat);
        end
        seg_x[3] = 4; seg_y[3] = 5;
        run_frame(5, lat, b, c);
        vectors++;
        if (c !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL collision_held: got %0d expected 1", c);
        end
        vectors++;
        if (collision !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL collision_clear: got %0d expected 0", collision);
        end
        model_frame(5);
    endtask

    task automatic test_bounds();
        int lat;
        bit b, c, occ, head;
        int heads;
        clear_segments();
        seg_x[0] = 10; seg_y[0] = 0;
        run_frame(2, lat, b, c);
        vectors++;
        if (out_of_bounds !== 1'b1 || collision !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bounds_oob: got oob=%0d coll=%0d expected 1 0", out_of_bounds, collision);
        end
        heads = 0;
        for (int t = 0; t < MAP_BITS; t++) begin
            read_tile(t % GRID_W, t / GRID_W, occ, head);
            heads += int'(head);
        end
        vectors++;
        if (heads !== 0) begin
            miscompares++;
            $display("[TB] FAIL bounds_no_head: got %0d head tiles expected 0", heads);
        end
        read_tile(0, 0, occ, head);
        vectors++;
        if (occ !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bounds_occ00: got %0d expected 1", occ);
        end

        seg_x[0] = 3; seg_y[0] = 3;
        seg_x[1] = 4; seg_y[1] = 4;
        run_frame(0, lat, b, c);
        vectors++;
        if (lat !== 4 || out_of_bounds !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL len0: got lat=%0d oob=%0d expected 4 0", lat, out_of_bounds);
        end
        read_tile(4, 4, occ, head);
        vectors++;
        if (occ !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL len0_body: got %0d expected 0", occ);
        end
        read_tile(3, 3, occ, head);
        vectors++;
        if ({occ, head} !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL len0_head: got occ=%0d head=%0d expected 1 1", occ, head);
        end

        for (int i = 0; i < MAX_SEG; i++) begin
            seg_x[i] = i % GRID_W;
            seg_y[i] = i / GRID_W;
        end
        run_frame(127, lat, b, c);
        vectors++;
        if (lat !== 103 || collision !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL len127: got lat=%0d coll=%0d expected 103 0", lat, collision);
        end
        model_frame(127);
    endtask

    function automatic logic [31:0] rand_coord();
        int r;
        r = $urandom_range(0, 9);
        if (r == 7) return 32'($urandom_range(10, 11));
        if (r == 8) return 32'($urandom);
        return 32'($urandom_range(0, 9));
    endfunction

    task automatic test_random();
        int lat, len, n;
        bit b, c, occ, head;
        for (int f = 0; f < 12; f++) begin
            len = $urandom_range(0, 127);
            for (int i = 0; i < MAX_SEG; i++) begin
                seg_x[i] = rand_coord();
                seg_y[i] = rand_coord();
            end
            n = (len == 0) ? 1 : ((len > MAX_SEG) ? MAX_SEG : len);
            if (n > 1 && $urandom_range(0, 1) == 1) begin
                seg_x[$urandom_range(1, n - 1)] = seg_x[0];
                seg_y[$urandom_range(1, n - 1)] = seg_y[0];
            end
            run_frame(len, lat, b, c);
            model_frame(len);
            vectors++;
            if (lat !== n + 3 || collision !== exp_coll || out_of_bounds !== exp_oob) begin
                miscompares++;
                $display("[TB] FAIL rand_frame%0d: got lat=%0d coll=%0d oob=%0d expected %0d %0d %0d",
                         f, lat, collision, out_of_bounds, n + 3, exp_coll, exp_oob);
            end
            for (int t = 0; t < 256; t++) begin
                read_tile(t % 16, t / 16, occ, head);
                vectors++;
                if (occ !== exp_occ(t % 16, t / 16) || head !== exp_head(t % 16, t / 16)) begin
                    miscompares++;
                    $display("[TB] FAIL rand_read f%0d (%0d,%0d): got occ=%0d head=%0d expected %0d %0d",
                             f, t % 16, t / 16, occ, head, exp_occ(t % 16, t / 16), exp_head(t % 16, t / 16));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int dones, first;
        clear_segments();
        for (int i = 0; i < 20; i++) begin
            seg_x[i] = i % GRID_W;
            seg_y[i] = 9;
        end
        snake_len = 7'd20;
        load_segments();
        frame_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        frame_start = 1'b0;
        dones = 0;
        first = -1;
        for (int k = 1; k <= 60; k++) begin
            if (k == 5) frame_start = 1'b1;
            if (k == 6) frame_start = 1'b0;
            @(negedge clk);
            if (frame_done) begin
                dones++;
                if (first < 0) first = k + 1;
            end
        end
        vectors++;
        if (dones !== 1 || first !== 23) begin
            miscompares++;
            $display("[TB] FAIL back_to_back: got %0d pulses first at %0d expected 1 at 23", dones, first);
        end
        model_frame(20);
    endtask

    task automatic test_freeze();
        int dones, busies, bad;
        bit occ, head;
        game_done = 1'b1;
        clear_segments();
        seg_x[0] = 5; seg_y[0] = 5;
        snake_len = 7'd1;
        load_segments();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        dones = 0;
        busies = 0;
        repeat (10) begin
            @(negedge clk);
            dones  += int'(frame_done);
            busies += int'(busy);
        end
        vectors++;
        if (dones !== 0 || busies !== 0) begin
            miscompares++;
            $display("[TB] FAIL freeze_idle: got done=%0d busy=%0d cycles expected 0 0", dones, busies);
        end
        bad = 0;
        for (int t = 0; t < MAP_BITS; t++) begin
            read_tile(t % GRID_W, t / GRID_W, occ, head);
            if (occ !== exp_occ(t % GRID_W, t / GRID_W) || head !== exp_head(t % GRID_W, t / GRID_W)) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("[TB] FAIL freeze_map: got %0d changed tiles expected 0", bad);
        end
        game_done = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        int dones, occs;
        bit occ, head;
        for (int i = 0; i < MAX_SEG; i++) begin
            seg_x[i] = i % GRID_W;
            seg_y[i] = (i / GRID_W) % GRID_H;
        end
        snake_len = 7'd50;
        load_segments();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        vectors++;
        if ({busy, collision, out_of_bounds} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_scan: got busy/coll/oob=%b expected 000",
                     {busy, collision, out_of_bounds});
        end
        dones = 0;
        repeat (60) begin
            @(negedge clk);
            dones += int'(frame_done);
        end
        vectors++;
        if (dones !== 0) begin
            miscompares++;
            $display("[TB] FAIL reset_abort: got %0d frame_done pulses expected 0", dones);
        end
        occs = 0;
        for (int t = 0; t < MAP_BITS; t++) begin
            read_tile(t % GRID_W, t / GRID_W, occ, head);
            occs += int'(occ) + int'(head);
        end
        vectors++;
        if (occs !== 0) begin
            miscompares++;
            $display("[TB] FAIL reset_empty_map: got %0d set tiles expected 0", occs);
        end
        model_empty();
    endtask

    initial begin
        reset       = 1'b0;
        frame_start = 1'b0;
        game_done   = 1'b0;
        snake_len   = 7'd0;
        x_values    = '0;
        y_values    = '0;
        rd_tx       = 4'd0;
        rd_ty       = 4'd0;
        clear_segments();
        model_empty();
        test_reset();
        test_basic();
        test_collision();
        test_bounds();
        test_random();
        test_back_to_back();
        test_freeze();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
